// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring counter and its monitor.
package ring_pkg;

  localparam int unsigned RING_WIDTH    = 4;
  localparam int unsigned RING_LOCK_CNT = 2;
  localparam int unsigned MAX_W         = 32;
  localparam int unsigned MAX_IW        = 5;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2,
    FAULT    = 2'd3
  } mon_state_e;

  // Rotate the low w bits of v left by one; bits at and above w are zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[MAX_IW'((i + 1) % w)] = v[MAX_IW'(i)];
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_W; i++) n += 32'(v[MAX_IW'(i)]);
    return n == 1;
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Combinational one-hot to binary index encoder; valid flags a legal one-hot input.
module onehot_to_index
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = RING_WIDTH
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     valid
);

  localparam int unsigned IW = $clog2(WIDTH);

  // OR of set-bit positions; only meaningful when valid is high.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[IW'(i)]) idx = idx | IW'(i);
    end
  end

  assign valid = is_onehot(MAX_W'(vec));

endmodule

// File: rtl/ring_monitor.sv
// Checks a one-hot ring for legal single-step rotation; reports phase, lock,
// revolutions and sticky fault status.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH    = RING_WIDTH,
  parameter int unsigned LOCK_CNT = RING_LOCK_CNT,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_q,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     locked,
  output logic                     rev_tick,
  output logic [REV_W-1:0]         rev_count,
  output logic                     err,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  mon_state_e       state, state_nxt;
  logic [GW-1:0]    good_cnt, good_nxt;
  logic [WIDTH-1:0] prev_q;
  logic             prev_valid;
  logic [IW-1:0]    idx;
  logic             onehot;
  logic             step_ok;
  logic             fault;
  logic             clear_rev;
  logic             tick;

  onehot_to_index #(.WIDTH(WIDTH)) u_enc (
    .vec   (ring_q),
    .idx   (idx),
    .valid (onehot)
  );

  assign step_ok = onehot && prev_valid && (ring_q == WIDTH'(rotl(MAX_W'(prev_q), WIDTH)));

  // Next-state and per-edge event decode.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    fault     = 1'b0;
    clear_rev = 1'b0;
    case (state)
      UNLOCKED: begin
        if (onehot) begin
          state_nxt = LOCKING;
          good_nxt  = '0;
        end
      end
      LOCKING: begin
        if (!step_ok) begin
          state_nxt = UNLOCKED;
          good_nxt  = '0;
        end else if (32'(good_cnt) + 32'd1 == LOCK_CNT) begin
          state_nxt = LOCKED;
          good_nxt  = '0;
          clear_rev = 1'b1;
        end else begin
          good_nxt = good_cnt + GW'(1);
        end
      end
      LOCKED: begin
        if (!step_ok) begin
          state_nxt = FAULT;
          fault     = 1'b1;
        end
      end
      FAULT:   state_nxt = UNLOCKED;
      default: state_nxt = UNLOCKED;
    endcase
    tick = (state == LOCKED) && step_ok && ring_q[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= UNLOCKED;
      good_cnt   <= '0;
      prev_q     <= '0;
      prev_valid <= 1'b0;
      phase      <= '0;
      locked     <= 1'b0;
      rev_tick   <= 1'b0;
      rev_count  <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      prev_q     <= ring_q;
      prev_valid <= 1'b1;
      locked     <= (state_nxt == LOCKED);
      phase      <= (state_nxt == LOCKED) ? idx : '0;
      rev_tick   <= tick;
      if (clear_rev)  rev_count <= '0;
      else if (tick)  rev_count <= rev_count + REV_W'(1);
      // A fault in the clearing cycle restarts the count at one.
      if (fault && clr_err) begin
        err       <= 1'b1;
        err_count <= ERR_W'(1);
      end else if (clr_err) begin
        err       <= 1'b0;
        err_count <= '0;
      end else if (fault) begin
        err <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed self-checking bench for ring_monitor: vector table plus corner sequences.
module tb_ring_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ring_q;
  logic       clr_err;
  logic [1:0] phase;
  logic       locked;
  logic       rev_tick;
  logic [7:0] rev_count;
  logic       err;
  logic [3:0] err_count;

  int checks = 0;
  int failures = 0;

  ring_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .ring_q    (ring_q),
    .clr_err   (clr_err),
    .phase     (phase),
    .locked    (locked),
    .rev_tick  (rev_tick),
    .rev_count (rev_count),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ring;
    logic       clr;
    logic [1:0] ph;
    logic       lk;
    logic       tk;
    logic [7:0] rv;
    logic       er;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [1:0] ph, input logic lk, input logic tk,
                         input logic [7:0] rv, input logic er, input logic [3:0] ec);
    chk({name, ".phase"},     32'(phase),     32'(ph));
    chk({name, ".locked"},    32'(locked),    32'(lk));
    chk({name, ".rev_tick"},  32'(rev_tick),  32'(tk));
    chk({name, ".rev_count"}, 32'(rev_count), 32'(rv));
    chk({name, ".err"},       32'(err),       32'(er));
    chk({name, ".err_count"}, 32'(err_count), 32'(ec));
  endtask

  // Drive one sample, clock it in, settle just after the edge.
  task automatic step(input logic [3:0] v, input logic c);
    ring_q  = v;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    ring_q  = 4'b0000;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    //           ring     clr  ph    lk  tk  rv    er  ec
    tbl[0]  = '{4'b0001, 0, 2'd0, 0, 0, 8'd0, 0, 4'd0};
    tbl[1]  = '{4'b0010, 0, 2'd0, 0, 0, 8'd0, 0, 4'd0};
    tbl[2]  = '{4'b0100, 0, 2'd2, 1, 0, 8'd0, 0, 4'd0};
    tbl[3]  = '{4'b1000, 0, 2'd3, 1, 0, 8'd0, 0, 4'd0};
    tbl[4]  = '{4'b0001, 0, 2'd0, 1, 1, 8'd1, 0, 4'd0};
    tbl[5]  = '{4'b0010, 0, 2'd1, 1, 0, 8'd1, 0, 4'd0};
    tbl[6]  = '{4'b0110, 0, 2'd0, 0, 0, 8'd1, 1, 4'd1};
    tbl[7]  = '{4'b0001, 0, 2'd0, 0, 0, 8'd1, 1, 4'd1};
    tbl[8]  = '{4'b0010, 0, 2'd0, 0, 0, 8'd1, 1, 4'd1};
    tbl[9]  = '{4'b0100, 0, 2'd0, 0, 0, 8'd1, 1, 4'd1};
    tbl[10] = '{4'b1000, 0, 2'd3, 1, 0, 8'd0, 1, 4'd1};
    tbl[11] = '{4'b0001, 0, 2'd0, 1, 1, 8'd1, 1, 4'd1};
    tbl[12] = '{4'b0010, 0, 2'd1, 1, 0, 8'd1, 1, 4'd1};
    tbl[13] = '{4'b1000, 0, 2'd0, 0, 0, 8'd1, 1, 4'd2};
    tbl[14] = '{4'b0001, 0, 2'd0, 0, 0, 8'd1, 1, 4'd2};
    tbl[15] = '{4'b0010, 0, 2'd0, 0, 0, 8'd1, 1, 4'd2};
    tbl[16] = '{4'b0100, 0, 2'd0, 0, 0, 8'd1, 1, 4'd2};
    tbl[17] = '{4'b1000, 0, 2'd3, 1, 0, 8'd0, 1, 4'd2};
    tbl[18] = '{4'b0001, 1, 2'd0, 1, 1, 8'd1, 0, 4'd0};

    do_reset();
    chk_all("reset", 2'd0, 0, 0, 8'd0, 0, 4'd0);

    // Lock, revolution, bad pattern, wrong step, clear.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].ring, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].ph, tbl[i].lk, tbl[i].tk,
              tbl[i].rv, tbl[i].er, tbl[i].ec);
    end

    // Dead ring never locks and never faults.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 1'b0);
      chk($sformatf("zero%0d.locked", i), 32'(locked), 32'd0);
      chk($sformatf("zero%0d.err", i),    32'(err),    32'd0);
    end

    // Error counter saturation, then clear colliding with a fault.
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    chk("sat.lock0", 32'(locked), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(4'b0000, 1'b0);
      chk($sformatf("sat%0d.err_count", i), 32'(err_count), (i > 15) ? 32'd15 : 32'(i));
      step(4'b0001, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b1000, 1'b0);
      chk($sformatf("sat%0d.relock", i), 32'(locked), 32'd1);
    end
    step(4'b0000, 1'b1);
    chk("clr_fault.err",       32'(err),       32'd1);
    chk("clr_fault.err_count", 32'(err_count), 32'd1);

    // Asynchronous reset mid-revolution while locked.
    clr_err = 1'b0;
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0001, 1'b0);
    chk("pre_arst.locked",    32'(locked),    32'd1);
    chk("pre_arst.rev_count", 32'(rev_count), 32'd1);
    ring_q = 4'b0010;
    #2;
    reset = 1'b0;
    #1;
    chk_all("arst", 2'd0, 0, 0, 8'd0, 0, 4'd0);
    @(posedge clk);
    #1;
    chk_all("arst_hold", 2'd0, 0, 0, 8'd0, 0, 4'd0);
    reset = 1'b1;
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    chk("relock2.locked", 32'(locked), 32'd0);
    step(4'b0100, 1'b0);
    chk("relock3.locked", 32'(locked), 32'd1);
    chk("relock3.phase",  32'(phase),  32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
